// File: rtl/m_store_buffer_pkg.sv
// Shared types and constants for the M-stage store buffer: op codes,
// memory-map bounds, the FIFO entry layout and an inclusive range helper.
package m_store_buffer_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_SB   = 2'b01,
    OP_SH   = 2'b10,
    OP_SW   = 2'b11
  } st_op_e;

  localparam logic [31:0] DM_LO_DEF   = 32'h0000_0000;
  localparam logic [31:0] DM_HI_DEF   = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO_DEF  = 32'h0000_7F00;
  localparam logic [31:0] TC0_HI_DEF  = 32'h0000_7F0B;
  localparam logic [31:0] TC0_CNT_DEF = 32'h0000_7F08;
  localparam logic [31:0] TC1_LO_DEF  = 32'h0000_7F10;
  localparam logic [31:0] TC1_HI_DEF  = 32'h0000_7F1B;
  localparam logic [31:0] TC1_CNT_DEF = 32'h0000_7F18;
  localparam logic [31:0] INT_LO_DEF  = 32'h0000_7F20;
  localparam logic [31:0] INT_HI_DEF  = 32'h0000_7F23;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] dat;
    logic [3:0]  be;
  } sb_entry_t;

  // Unsigned offset compare: avoids a constant-true test when lo is zero.
  function automatic logic in_rng(input logic [31:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/m_store_buffer_fmt.sv
// Combinational store formatter: op/addr/data -> lane byte enables, lane-aligned
// write data and the store address exception.
module m_store_buffer_fmt
  import m_store_buffer_pkg::*;
#(
  parameter logic [31:0] DM_LO   = DM_LO_DEF,
  parameter logic [31:0] DM_HI   = DM_HI_DEF,
  parameter logic [31:0] TC0_LO  = TC0_LO_DEF,
  parameter logic [31:0] TC0_HI  = TC0_HI_DEF,
  parameter logic [31:0] TC0_CNT = TC0_CNT_DEF,
  parameter logic [31:0] TC1_LO  = TC1_LO_DEF,
  parameter logic [31:0] TC1_HI  = TC1_HI_DEF,
  parameter logic [31:0] TC1_CNT = TC1_CNT_DEF,
  parameter logic [31:0] INT_LO  = INT_LO_DEF,
  parameter logic [31:0] INT_HI  = INT_HI_DEF
) (
  input  logic [1:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        exc_o
);

  logic align_err;
  logic in_map;
  logic timer_err;
  logic sub_word;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (op_i)
      OP_SB: begin
        be_o    = 4'b0001 << addr_i[1:0];
        wdata_o = data_i << {addr_i[1:0], 3'b000};
      end
      OP_SH: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = addr_i[1] ? (data_i << 16) : data_i;
      end
      OP_SW: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  assign sub_word  = (op_i == OP_SB) || (op_i == OP_SH);
  assign align_err = ((op_i == OP_SW) && (addr_i[1:0] != 2'b00)) ||
                     ((op_i == OP_SH) && addr_i[0]);
  assign in_map    = in_rng(addr_i, DM_LO, DM_HI)   || in_rng(addr_i, TC0_LO, TC0_HI) ||
                     in_rng(addr_i, TC1_LO, TC1_HI) || in_rng(addr_i, INT_LO, INT_HI);
  // Timer count registers are read-only; timers accept only full-word writes.
  assign timer_err = in_rng(addr_i, TC0_CNT, TC0_HI) || in_rng(addr_i, TC1_CNT, TC1_HI) ||
                     (sub_word && in_rng(addr_i, TC0_LO, TC1_HI));
  assign exc_o     = (op_i != OP_NONE) && (align_err || !in_map || timer_err);

endmodule

// File: rtl/m_store_buffer.sv
// M-stage store buffer: formats and checks stores, queues legal ones in a
// DEPTH-entry FIFO with optional tail merging, drains one per cycle to the bus.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter bit          MERGE   = 1'b1,
  parameter logic [31:0] DM_LO   = DM_LO_DEF,
  parameter logic [31:0] DM_HI   = DM_HI_DEF,
  parameter logic [31:0] TC0_LO  = TC0_LO_DEF,
  parameter logic [31:0] TC0_HI  = TC0_HI_DEF,
  parameter logic [31:0] TC0_CNT = TC0_CNT_DEF,
  parameter logic [31:0] TC1_LO  = TC1_LO_DEF,
  parameter logic [31:0] TC1_HI  = TC1_HI_DEF,
  parameter logic [31:0] TC1_CNT = TC1_CNT_DEF,
  parameter logic [31:0] INT_LO  = INT_LO_DEF,
  parameter logic [31:0] INT_HI  = INT_HI_DEF,
  localparam int         PW      = $clog2(DEPTH),
  localparam int         CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    st_op,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic          req,
  output logic          exc_ades,
  output logic          st_stall,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  output logic          bus_valid,
  output logic [31:0]   bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_byteen,
  input  logic          bus_ready,
  output logic [CW-1:0] sb_count
);

  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic [PW-1:0]    tail_m1;
  logic             merge_hit;
  logic             accept;
  logic             push;
  logic             pop;
  logic             hit_any;
  logic             ld_addr_unused;

  m_store_buffer_fmt #(
    .DM_LO  (DM_LO),
    .DM_HI  (DM_HI),
    .TC0_LO (TC0_LO),
    .TC0_HI (TC0_HI),
    .TC0_CNT(TC0_CNT),
    .TC1_LO (TC1_LO),
    .TC1_HI (TC1_HI),
    .TC1_CNT(TC1_CNT),
    .INT_LO (INT_LO),
    .INT_HI (INT_HI)
  ) u_fmt (
    .op_i   (st_op),
    .addr_i (st_addr),
    .data_i (st_data),
    .be_o   (fmt_be),
    .wdata_o(fmt_wdata),
    .exc_o  (exc_ades)
  );

  // The head may already be on the bus, so merging needs at least two entries.
  assign tail_m1   = tail_q - 1'b1;
  assign merge_hit = MERGE && (cnt_q >= CW'(2)) && (ent_q[tail_m1].wa == st_addr[31:2]);
  assign st_stall  = (cnt_q == CW'(DEPTH)) && !merge_hit;
  assign accept    = (st_op != OP_NONE) && !req && !exc_ades && !st_stall;
  assign push      = accept && !merge_hit;
  assign bus_valid = (cnt_q != '0);
  assign pop       = bus_valid && bus_ready;
  assign sb_count  = cnt_q;

  assign bus_addr   = bus_valid ? {ent_q[head_q].wa, 2'b00} : 32'h0;
  assign bus_wdata  = bus_valid ? ent_q[head_q].dat : 32'h0;
  assign bus_byteen = bus_valid ? ent_q[head_q].be : 4'b0000;

  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].wa == ld_addr[31:2])) hit_any = 1'b1;
    end
  end
  assign ld_hazard      = ld_valid && hit_any;
  assign ld_addr_unused = ^ld_addr[1:0];

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (accept && merge_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (fmt_be[b]) ent_d[tail_m1].dat[8*b +: 8] = fmt_wdata[8*b +: 8];
      end
      ent_d[tail_m1].be = ent_q[tail_m1].be | fmt_be;
    end else if (push) begin
      ent_d[tail_q] = '{wa: st_addr[31:2], dat: fmt_wdata, be: fmt_be};
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q  <= '{default: '0};
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
